// File: rtl/hazard_control_unit.sv
// ============================================================================
// Module      : hazard_control_unit
// Description : ID/EX hazard unit covering load-use and WAW, mul/div busy, and branch flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_control_unit #(
    parameter int ADDR_W    = 5,
    parameter int NUM_SRC   = 2,
    parameter int LOAD_LAT  = 1,
    parameter int MD_CYCLES = 4,
    parameter int CHECK_WAW = 1,
    parameter int ZERO_SAFE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_valid,
    input  logic [ADDR_W-1:0]         id_tar_addr,
    input  logic                      id_tar_valid,
    input  logic                      id_is_muldiv,
    input  logic                      id_uses_hilo,
    input  logic [ADDR_W-1:0]         ex_tar_addr,
    input  logic                      ex_mem_read,
    input  logic                      ex_branch_taken,
    output logic                      pc_write,
    output logic                      if_id_write,
    output logic                      stall,
    output logic                      if_id_flush,
    output logic                      md_busy
);

    localparam int LD_W = $clog2(LOAD_LAT + 1);
    localparam int MD_W = $clog2(MD_CYCLES + 1);

    localparam logic [LD_W-1:0] c_ld_reload = LD_W'(LOAD_LAT - 1);
    localparam logic [LD_W-1:0] c_ld_one    = LD_W'(1);
    localparam logic [MD_W-1:0] c_md_reload = MD_W'(MD_CYCLES);
    localparam logic [MD_W-1:0] c_md_one    = MD_W'(1);

    logic [LD_W-1:0]    r_ld_cnt;
    logic [LD_W-1:0]    w_ld_cnt_nxt;
    logic [MD_W-1:0]    r_md_cnt;
    logic [MD_W-1:0]    w_md_cnt_nxt;
    logic [NUM_SRC-1:0] w_src_hit;
    logic               w_waw_hit;
    logic               w_ld_hit;
    logic               w_ld_stall;
    logic               w_md_stall;
    logic               w_md_issue;

    function automatic logic addr_match(input logic [ADDR_W-1:0] a,
                                        input logic [ADDR_W-1:0] b);
        return (a == b) && !((ZERO_SAFE != 0) && (a == '0));
    endfunction

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            assign w_src_hit[i] = id_src_valid[i] &&
                                  addr_match(id_src_addr[i*ADDR_W +: ADDR_W], ex_tar_addr);
        end
    endgenerate

    assign w_waw_hit  = (CHECK_WAW != 0) && id_tar_valid && addr_match(id_tar_addr, ex_tar_addr);
    assign w_ld_hit   = ex_mem_read && ((|w_src_hit) || w_waw_hit);
    assign w_ld_stall = w_ld_hit || (r_ld_cnt != '0);
    assign w_md_stall = (r_md_cnt != '0) && (id_uses_hilo || id_is_muldiv);
    assign w_md_issue = id_is_muldiv && !w_ld_stall && !w_md_stall && !ex_branch_taken;

    // The first stall cycle is the hit itself, so the counter only holds the remainder.
    always_comb begin
        w_ld_cnt_nxt = r_ld_cnt;
        if (ex_branch_taken) begin
            w_ld_cnt_nxt = '0;
        end else if (r_ld_cnt != '0) begin
            w_ld_cnt_nxt = r_ld_cnt - c_ld_one;
        end else if (w_ld_hit) begin
            w_ld_cnt_nxt = c_ld_reload;
        end
    end

    // An issued mul/div is committed, so a flush leaves its countdown running.
    always_comb begin
        w_md_cnt_nxt = r_md_cnt;
        if (w_md_issue) begin
            w_md_cnt_nxt = c_md_reload;
        end else if (r_md_cnt != '0) begin
            w_md_cnt_nxt = r_md_cnt - c_md_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_cnt <= '0;
            r_md_cnt <= '0;
        end else begin
            r_ld_cnt <= w_ld_cnt_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    // Outputs are forced to the free-running state while reset is held, even if inputs show a hazard.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        stall       = 1'b0;
        if_id_flush = 1'b0;
        md_busy     = 1'b0;
        if (!rst) begin
            md_busy = (r_md_cnt != '0);
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                stall       = 1'b1;
            end else if (w_ld_stall || w_md_stall) begin
                stall       = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// Module      : tb_hazard_control_unit
// Description : Directed self-checking bench over three parameter sets of the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

    localparam int ADDR_W  = 5;
    localparam int NUM_SRC = 2;

    // Output vector layout: {pc_write, if_id_write, stall, if_id_flush, md_busy}
    localparam logic [4:0] c_run = 5'b11000;
    localparam logic [4:0] c_stl = 5'b00100;
    localparam logic [4:0] c_fls = 5'b11110;
    localparam logic [4:0] c_bsy = 5'b00001;

    logic                      clk;
    logic                      rst;
    logic [NUM_SRC*ADDR_W-1:0] id_src_addr;
    logic [NUM_SRC-1:0]        id_src_valid;
    logic [ADDR_W-1:0]         id_tar_addr;
    logic                      id_tar_valid;
    logic                      id_is_muldiv;
    logic                      id_uses_hilo;
    logic [ADDR_W-1:0]         ex_tar_addr;
    logic                      ex_mem_read;
    logic                      ex_branch_taken;

    logic [4:0] v1, v3, vn;
    int checks = 0;
    int errors = 0;

    // d1: defaults; d3: LOAD_LAT=3 with WAW; dn: LOAD_LAT=1, no WAW, address 0 not protected
    hazard_control_unit #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .LOAD_LAT(1), .MD_CYCLES(4),
                          .CHECK_WAW(1), .ZERO_SAFE(1)) d1 (
        .clk(clk), .rst(rst), .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
        .id_tar_addr(id_tar_addr), .id_tar_valid(id_tar_valid), .id_is_muldiv(id_is_muldiv),
        .id_uses_hilo(id_uses_hilo), .ex_tar_addr(ex_tar_addr), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .pc_write(v1[4]), .if_id_write(v1[3]),
        .stall(v1[2]), .if_id_flush(v1[1]), .md_busy(v1[0]));

    hazard_control_unit #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .LOAD_LAT(3), .MD_CYCLES(4),
                          .CHECK_WAW(1), .ZERO_SAFE(1)) d3 (
        .clk(clk), .rst(rst), .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
        .id_tar_addr(id_tar_addr), .id_tar_valid(id_tar_valid), .id_is_muldiv(id_is_muldiv),
        .id_uses_hilo(id_uses_hilo), .ex_tar_addr(ex_tar_addr), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .pc_write(v3[4]), .if_id_write(v3[3]),
        .stall(v3[2]), .if_id_flush(v3[1]), .md_busy(v3[0]));

    hazard_control_unit #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .LOAD_LAT(1), .MD_CYCLES(4),
                          .CHECK_WAW(0), .ZERO_SAFE(0)) dn (
        .clk(clk), .rst(rst), .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
        .id_tar_addr(id_tar_addr), .id_tar_valid(id_tar_valid), .id_is_muldiv(id_is_muldiv),
        .id_uses_hilo(id_uses_hilo), .ex_tar_addr(ex_tar_addr), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .pc_write(vn[4]), .if_id_write(vn[3]),
        .stall(vn[2]), .if_id_flush(vn[1]), .md_busy(vn[0]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        id_src_addr     = '0;
        id_src_valid    = '0;
        id_tar_addr     = '0;
        id_tar_valid    = 1'b0;
        id_is_muldiv    = 1'b0;
        id_uses_hilo    = 1'b0;
        ex_tar_addr     = '0;
        ex_mem_read     = 1'b0;
        ex_branch_taken = 1'b0;
    endtask

    task automatic load_hazard(input logic [ADDR_W-1:0] addr);
        ex_mem_read  = 1'b1;
        ex_tar_addr  = addr;
        id_src_addr  = {5'd0, addr};
        id_src_valid = 2'b01;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        load_hazard(5'd8);
        #1;
        chk("reset_d1", v1, c_run);
        chk("reset_d3", v3, c_run);
        idle();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Load-use: one stall for LOAD_LAT=1, three for LOAD_LAT=3
        load_hazard(5'd8);
        #1;
        chk("ld_c0_d1", v1, c_stl);
        chk("ld_c0_d3", v3, c_stl);
        chk("ld_c0_dn", vn, c_stl);
        next_cycle();
        ex_mem_read = 1'b0;
        #1;
        chk("ld_c1_d1", v1, c_run);
        chk("ld_c1_dn", vn, c_run);
        chk("ld_c1_d3", v3, c_stl);
        next_cycle();
        chk("ld_c2_d3", v3, c_stl);
        next_cycle();
        chk("ld_c3_d3", v3, c_run);

        // Hazard held a second cycle must not reload the LOAD_LAT=3 countdown
        load_hazard(5'd8);
        next_cycle();
        #1;
        chk("hold_c1_d3", v3, c_stl);
        next_cycle();
        ex_mem_read = 1'b0;
        #1;
        chk("hold_c2_d3", v3, c_stl);
        next_cycle();
        chk("hold_c3_d3", v3, c_run);
        idle();

        // Address 0 is only a hazard when zero protection is off
        load_hazard(5'd0);
        #1;
        chk("zero_d1", v1, c_run);
        chk("zero_dn", vn, c_stl);
        ex_mem_read = 1'b0;
        next_cycle();
        chk("zero_after_dn", vn, c_run);

        // Operand 1 match only counts when its valid bit is set
        ex_mem_read  = 1'b1;
        ex_tar_addr  = 5'd9;
        id_src_addr  = {5'd9, 5'd3};
        id_src_valid = 2'b01;
        #1;
        chk("src1_invalid_d1", v1, c_run);
        id_src_valid = 2'b10;
        #1;
        chk("src1_valid_d1", v1, c_stl);
        idle();

        // WAW against the load target
        ex_mem_read  = 1'b1;
        ex_tar_addr  = 5'd8;
        id_tar_addr  = 5'd8;
        id_tar_valid = 1'b1;
        id_src_addr  = {5'd4, 5'd3};
        id_src_valid = 2'b11;
        #1;
        chk("waw_d1", v1, c_stl);
        chk("waw_d3", v3, c_stl);
        chk("waw_dn", vn, c_run);
        idle();
        next_cycle();

        // Mul/div: issue, then mflo stalls exactly MD_CYCLES cycles
        id_is_muldiv = 1'b1;
        #1;
        chk("md_issue_d1", v1, c_run);
        next_cycle();
        id_is_muldiv = 1'b0;
        id_uses_hilo = 1'b1;
        #1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("md_busy_c%0d_d1", k), v1, c_stl | c_bsy);
            next_cycle();
        end
        chk("md_done_d1", v1, c_run);
        chk("md_done_d3", v3, c_run);

        // Unrelated instruction during busy proceeds; a second mul/div waits
        id_uses_hilo = 1'b0;
        id_is_muldiv = 1'b1;
        next_cycle();
        id_is_muldiv = 1'b0;
        #1;
        chk("md_add_d1", v1, c_run | c_bsy);
        id_is_muldiv = 1'b1;
        #1;
        chk("md_md_d1", v1, c_stl | c_bsy);
        id_is_muldiv = 1'b0;
        id_uses_hilo = 1'b1;
        #1;
        chk("md_pre_rst_d1", v1, c_stl | c_bsy);

        // Asynchronous reset between edges clears busy immediately
        #1;
        rst = 1'b1;
        #1;
        chk("md_rst_d1", v1, c_run);
        chk("md_rst_dn", vn, c_run);
        rst = 1'b0;
        #1;
        chk("md_post_rst_d1", v1, c_run);
        idle();
        next_cycle();

        // Taken branch during the LOAD_LAT=3 countdown flushes and clears it
        load_hazard(5'd8);
        next_cycle();
        ex_mem_read = 1'b0;
        next_cycle();
        ex_branch_taken = 1'b1;
        #1;
        chk("br_flush_d3", v3, c_fls);
        chk("br_flush_d1", v1, c_fls);
        next_cycle();
        ex_branch_taken = 1'b0;
        #1;
        chk("br_after_d3", v3, c_run);

        // Flush blocks a mul/div issue in the same cycle
        ex_branch_taken = 1'b1;
        id_is_muldiv    = 1'b1;
        #1;
        chk("br_md_d1", v1, c_fls);
        next_cycle();
        idle();
        id_uses_hilo = 1'b1;
        #1;
        chk("br_md_after_d1", v1, c_run);

        // Load and mul/div hazards together give a single stall, counters advance independently
        idle();
        id_is_muldiv = 1'b1;
        next_cycle();
        id_is_muldiv = 1'b0;
        id_uses_hilo = 1'b1;
        load_hazard(5'd8);
        #1;
        chk("both_c1_d3", v3, c_stl | c_bsy);
        next_cycle();
        ex_mem_read  = 1'b0;
        id_uses_hilo = 1'b0;
        #1;
        chk("both_c2_d3", v3, c_stl | c_bsy);
        chk("both_c2_d1", v1, c_run | c_bsy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
